// File: rtl/wfa_traceback_stream.sv
// WFA affine-gap traceback walker: follows pointer memory from a final (score, diag, state)
// back to score 0 and streams a run-length-encoded CIGAR over a one-beat valid/ready register.
module wfa_traceback_stream #(
    parameter int unsigned WF_W   = 8,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 4,
    parameter int unsigned RUN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [WF_W-1:0]   i_start_score,
    input  logic [WF_W-1:0]   i_start_diag,
    input  logic [1:0]        i_start_state,
    output logic              o_meta_rd,
    output logic [WF_W-1:0]   o_meta_addr,
    input  logic [DATA_W-1:0] i_meta_kmin,
    input  logic [DATA_W-1:0] i_meta_offset,
    output logic              o_ptr_rd,
    output logic [ADDR_W-1:0] o_ptr_addr,
    input  logic [3:0]        i_ptr_data,
    output logic              o_op_valid,
    input  logic              i_op_ready,
    output logic [1:0]        o_op_code,
    output logic [RUN_W-1:0]  o_op_len,
    output logic              o_op_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned XW  = WF_W + 1;
    localparam int unsigned MW0 = (DATA_W > XW) ? DATA_W : XW;
    localparam int unsigned SW  = ((MW0 > ADDR_W) ? MW0 : ADDR_W) + 1;
    localparam int unsigned CW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [1:0]       OpM    = 2'b00;
    localparam logic [1:0]       OpI    = 2'b01;
    localparam logic [1:0]       OpD    = 2'b10;
    localparam logic [1:0]       OpEnd  = 2'b11;
    localparam logic [RUN_W-1:0] LenMax = '1;

    typedef enum logic [2:0] {
        StIdle, StMetaReq, StMetaWait, StPtrReq, StPtrWait, StStep, StFlush, StDone
    } state_t;

    state_t            r_st;
    logic [CW-1:0]     r_cnt;
    logic [WF_W-1:0]   r_score;
    logic [WF_W-1:0]   r_diag;
    logic [1:0]        r_state;
    logic [3:0]        r_ptr_data;
    logic [1:0]        r_acc_code;
    logic [RUN_W-1:0]  r_acc_len;
    logic              r_meta_rd;
    logic              r_ptr_rd;
    logic [ADDR_W-1:0] r_ptr_addr;
    logic              r_op_valid;
    logic [1:0]        r_op_code;
    logic [RUN_W-1:0]  r_op_len;
    logic              r_op_last;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic signed [XW-1:0] w_diag_x;
    logic signed [XW-1:0] w_kmin_x;
    logic signed [XW-1:0] w_rel;
    logic [SW-1:0]        w_sum;
    logic                 w_addr_err;
    logic [1:0]           w_emit_code;
    logic                 w_end;
    logic                 w_ext;
    logic [WF_W-1:0]      w_next_diag;
    logic [WF_W-1:0]      w_next_score;
    logic [1:0]           w_next_state;
    logic                 w_extend;
    logic                 w_push;
    logic                 w_stall;

    function automatic logic le_zero(input logic [WF_W-1:0] v);
        return v[WF_W-1] || (v == '0);
    endfunction

    // Pointer address from the wavefront metadata; rel is checked before truncation.
    assign w_diag_x   = XW'(signed'(r_diag));
    assign w_kmin_x   = XW'(signed'(i_meta_kmin));
    assign w_rel      = w_diag_x - w_kmin_x;
    assign w_sum      = SW'(i_meta_offset) + SW'(unsigned'(w_rel));
    assign w_addr_err = w_rel[XW-1] || (w_sum[SW-1:ADDR_W] != '0);

    always_comb begin
        w_emit_code = r_state;
        w_end       = 1'b0;
        w_ext       = 1'b0;
        w_next_diag = r_diag;
        if (r_state == OpM) begin
            w_emit_code = r_ptr_data[1:0];
            w_end       = (r_ptr_data[1:0] == OpEnd);
        end
        case (w_emit_code)
            OpI: begin
                w_ext       = r_ptr_data[2];
                w_next_diag = r_diag - WF_W'(1);
            end
            OpD: begin
                w_ext       = r_ptr_data[3];
                w_next_diag = r_diag + WF_W'(1);
            end
            default: ;
        endcase
        w_next_state = w_ext ? w_emit_code : OpM;
        w_next_score = w_ext ? r_score - WF_W'(2) : r_score - WF_W'(1);
    end

    assign w_extend = (r_acc_len != '0) && (r_acc_code == w_emit_code) && (r_acc_len != LenMax);
    assign w_push   = !w_end && (r_acc_len != '0) && !w_extend;
    assign w_stall  = r_op_valid && !i_op_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st       <= StIdle;
            r_cnt      <= '0;
            r_score    <= '0;
            r_diag     <= '0;
            r_state    <= OpM;
            r_ptr_data <= '0;
            r_acc_code <= OpM;
            r_acc_len  <= '0;
            r_meta_rd  <= 1'b0;
            r_ptr_rd   <= 1'b0;
            r_ptr_addr <= '0;
            r_op_valid <= 1'b0;
            r_op_code  <= OpM;
            r_op_len   <= '0;
            r_op_last  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_meta_rd <= 1'b0;
            r_ptr_rd  <= 1'b0;
            r_done    <= 1'b0;
            if (r_op_valid && i_op_ready) begin
                r_op_valid <= 1'b0;
            end
            case (r_st)
                StIdle: begin
                    if (i_start) begin
                        r_score    <= i_start_score;
                        r_diag     <= i_start_diag;
                        r_state    <= i_start_state;
                        r_err      <= 1'b0;
                        r_acc_code <= OpM;
                        r_acc_len  <= '0;
                        r_busy     <= 1'b1;
                        if (le_zero(i_start_score) || (i_start_state == OpEnd)) begin
                            r_st <= StFlush;
                        end else begin
                            r_st      <= StMetaReq;
                            r_meta_rd <= 1'b1;
                        end
                    end
                end
                StMetaReq: begin
                    r_cnt <= '0;
                    r_st  <= StMetaWait;
                end
                StMetaWait: begin
                    if (r_cnt == CW'(RD_LAT - 1)) begin
                        if (w_addr_err) begin
                            r_err <= 1'b1;
                            r_st  <= StFlush;
                        end else begin
                            r_ptr_addr <= w_sum[ADDR_W-1:0];
                            r_ptr_rd   <= 1'b1;
                            r_st       <= StPtrReq;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StPtrReq: begin
                    r_cnt <= '0;
                    r_st  <= StPtrWait;
                end
                StPtrWait: begin
                    if (r_cnt == CW'(RD_LAT - 1)) begin
                        r_ptr_data <= i_ptr_data;
                        r_st       <= StStep;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StStep: begin
                    if (w_end) begin
                        r_st <= StFlush;
                    end else if (!(w_push && w_stall)) begin
                        r_score <= w_next_score;
                        r_diag  <= w_next_diag;
                        r_state <= w_next_state;
                        if (w_extend) begin
                            r_acc_len <= r_acc_len + RUN_W'(1);
                        end else begin
                            r_acc_code <= w_emit_code;
                            r_acc_len  <= RUN_W'(1);
                        end
                        if (w_push) begin
                            r_op_valid <= 1'b1;
                            r_op_code  <= r_acc_code;
                            r_op_len   <= r_acc_len;
                            r_op_last  <= 1'b0;
                        end
                        if (le_zero(w_next_score)) begin
                            r_st <= StFlush;
                        end else begin
                            r_st      <= StMetaReq;
                            r_meta_rd <= 1'b1;
                        end
                    end
                end
                StFlush: begin
                    if (r_acc_len == '0) begin
                        r_st <= StDone;
                    end else if (!w_stall) begin
                        r_op_valid <= 1'b1;
                        r_op_code  <= r_acc_code;
                        r_op_len   <= r_acc_len;
                        r_op_last  <= 1'b1;
                        r_acc_len  <= '0;
                        r_st       <= StDone;
                    end
                end
                StDone: begin
                    // Completion waits for the last beat to leave the output register.
                    if (!r_op_valid || i_op_ready) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                        r_st   <= StIdle;
                    end
                end
                default: r_st <= StIdle;
            endcase
        end
    end

    assign o_meta_rd   = r_meta_rd;
    assign o_meta_addr = r_score;
    assign o_ptr_rd    = r_ptr_rd;
    assign o_ptr_addr  = r_ptr_addr;
    assign o_op_valid  = r_op_valid;
    assign o_op_code   = r_op_code;
    assign o_op_len    = r_op_len;
    assign o_op_last   = r_op_last;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_wfa_traceback_stream.sv
// Bench for wfa_traceback_stream: latency-accurate memory models, directed traces, then
// randomized traces with backpressure compared against a score-walk reference model.
module tb_wfa_traceback_stream;

    localparam int WF_W   = 8;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 4;
    localparam int RUN_W  = 2;

    logic              clk;
    logic              rst;
    logic              i_start;
    logic [WF_W-1:0]   i_start_score;
    logic [WF_W-1:0]   i_start_diag;
    logic [1:0]        i_start_state;
    logic              o_meta_rd;
    logic [WF_W-1:0]   o_meta_addr;
    logic [DATA_W-1:0] i_meta_kmin;
    logic [DATA_W-1:0] i_meta_offset;
    logic              o_ptr_rd;
    logic [ADDR_W-1:0] o_ptr_addr;
    logic [3:0]        i_ptr_data;
    logic              o_op_valid;
    logic              i_op_ready;
    logic [1:0]        o_op_code;
    logic [RUN_W-1:0]  o_op_len;
    logic              o_op_last;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    wfa_traceback_stream #(
        .WF_W(WF_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .RUN_W(RUN_W)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_start_score(i_start_score),
        .i_start_diag(i_start_diag), .i_start_state(i_start_state), .o_meta_rd(o_meta_rd),
        .o_meta_addr(o_meta_addr), .i_meta_kmin(i_meta_kmin), .i_meta_offset(i_meta_offset),
        .o_ptr_rd(o_ptr_rd), .o_ptr_addr(o_ptr_addr), .i_ptr_data(i_ptr_data),
        .o_op_valid(o_op_valid), .i_op_ready(i_op_ready), .o_op_code(o_op_code),
        .o_op_len(o_op_len), .o_op_last(o_op_last), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories: valid data only in the cycle RD_LAT after the strobe, noise otherwise.
    logic [7:0] kmin_mem [256];
    logic [7:0] off_mem  [256];
    logic [3:0] ptr_mem  [1024];
    logic [7:0] kp  [RD_LAT];
    logic [7:0] ofp [RD_LAT];
    logic [3:0] pp  [RD_LAT];

    always @(posedge clk) begin
        kp[0]  <= o_meta_rd ? kmin_mem[o_meta_addr] : 8'($urandom);
        ofp[0] <= o_meta_rd ? off_mem[o_meta_addr] : 8'($urandom);
        pp[0]  <= o_ptr_rd ? ptr_mem[o_ptr_addr] : 4'($urandom);
        for (int i = 1; i < RD_LAT; i++) begin
            kp[i]  <= kp[i-1];
            ofp[i] <= ofp[i-1];
            pp[i]  <= pp[i-1];
        end
    end
    assign i_meta_kmin   = kp[RD_LAT-1];
    assign i_meta_offset = ofp[RD_LAT-1];
    assign i_ptr_data    = pp[RD_LAT-1];

    int rdy_mode;  // 0 always ready, 1 random, 2 held low
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) i_op_ready = 1'b1;
        else if (rdy_mode == 1) i_op_ready = ($urandom_range(0, 3) != 0);
        else i_op_ready = 1'b0;
    end

    int cyc, done_cnt, done_busy_bad, last_hs_cyc, done_cyc;
    int gq_code[$], gq_len[$], gq_last[$], mq[$], pq[$];
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (o_op_valid && i_op_ready) begin
                gq_code.push_back(int'(o_op_code));
                gq_len.push_back(int'(o_op_len));
                gq_last.push_back(int'(o_op_last));
                if (o_op_last) last_hs_cyc = cyc;
            end
            if (o_meta_rd) mq.push_back(int'(o_meta_addr));
            if (o_ptr_rd) pq.push_back(int'(o_ptr_addr));
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                if (o_busy) done_busy_bad++;
            end
        end
    end

    int checks, errors;
    int exp_code[$], exp_len[$], exp_last[$], exp_meta[$], exp_ptr[$];
    int exp_err;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int wrapw(input int x);
        logic [WF_W-1:0] t;
        t = x[WF_W-1:0];
        return int'($signed(t));
    endfunction

    // Reference: walk the traceback on integers, then run-length encode the op list.
    task automatic model(input int sc0, input int dg0, input int st0);
        int score, diag, st, em, kmin, off, rel, p, op, ext;
        int ops[$];
        int maxlen;
        maxlen = (1 << RUN_W) - 1;
        exp_code.delete(); exp_len.delete(); exp_last.delete();
        exp_meta.delete(); exp_ptr.delete();
        exp_err = 0;
        score = wrapw(sc0);
        diag = wrapw(dg0);
        st = st0;
        if (score > 0 && st != 3) begin
            for (int n = 0; n < 1000; n++) begin
                em = score & ((1 << WF_W) - 1);
                exp_meta.push_back(em);
                kmin = int'($signed(kmin_mem[em]));
                off = int'(off_mem[em]);
                rel = diag - kmin;
                if (rel < 0 || off + rel >= (1 << ADDR_W)) begin
                    exp_err = 1;
                    break;
                end
                exp_ptr.push_back(off + rel);
                p = int'(ptr_mem[off + rel]);
                op = (st == 0) ? (p & 3) : st;
                if (op == 3) break;
                ext = (op == 1) ? ((p >> 2) & 1) : (op == 2) ? ((p >> 3) & 1) : 0;
                if (op == 1) diag = wrapw(diag - 1);
                if (op == 2) diag = wrapw(diag + 1);
                st = (ext != 0) ? op : 0;
                score = wrapw(score - ((ext != 0) ? 2 : 1));
                ops.push_back(op);
                if (score <= 0) break;
            end
        end
        foreach (ops[i]) begin
            if (exp_code.size() > 0 && exp_code[$] == ops[i] && exp_len[$] < maxlen)
                exp_len[$] = exp_len[$] + 1;
            else begin
                exp_code.push_back(ops[i]);
                exp_len.push_back(1);
                exp_last.push_back(0);
            end
        end
        if (exp_last.size() > 0) exp_last[$] = 1;
    endtask

    // mode: 0 plain, 1 extra start pulse while busy, 2 hold first beat with ready low
    task automatic run_trace(input string tag, input int sc, input int dg, input int st,
                             input int mode);
        int b0, m0, p0, d0, n, nb, nm, np, hc, hl, hla;
        model(sc, dg, st);
        b0 = gq_code.size(); m0 = mq.size(); p0 = pq.size(); d0 = done_cnt;
        if (mode == 2) rdy_mode = 2;
        @(posedge clk); #1;
        i_start = 1'b1;
        i_start_score = WF_W'(sc);
        i_start_diag = WF_W'(dg);
        i_start_state = 2'(st);
        @(posedge clk); #1;
        i_start = 1'b0;
        if (mode == 2) begin
            n = 0;
            while (!o_op_valid && n < 1000) begin
                @(posedge clk); #1;
                n++;
            end
            chk({tag, " hold_valid"}, int'(o_op_valid), 1);
            hc = int'(o_op_code); hl = int'(o_op_len); hla = int'(o_op_last);
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                chk({tag, " hold_valid"}, int'(o_op_valid), 1);
                chk({tag, " hold_code"}, int'(o_op_code), hc);
                chk({tag, " hold_len"}, int'(o_op_len), hl);
                chk({tag, " hold_last"}, int'(o_op_last), hla);
                chk({tag, " hold_no_meta_rd"}, int'(o_meta_rd), 0);
            end
            rdy_mode = 0;
        end
        n = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (mode == 1 && n == 3) begin
                i_start = 1'b1;
                i_start_score = WF_W'($urandom_range(1, 100));
                i_start_diag = WF_W'($urandom);
                i_start_state = 2'b00;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " done_count"}, done_cnt - d0, 1);
        chk({tag, " busy_idle"}, int'(o_busy), 0);
        chk({tag, " err"}, int'(o_err), exp_err);
        nb = gq_code.size() - b0;
        chk({tag, " beats"}, nb, exp_code.size());
        for (int i = 0; i < nb && i < exp_code.size(); i++) begin
            chk($sformatf("%s beat%0d code", tag, i), gq_code[b0+i], exp_code[i]);
            chk($sformatf("%s beat%0d len", tag, i), gq_len[b0+i], exp_len[i]);
            chk($sformatf("%s beat%0d last", tag, i), gq_last[b0+i], exp_last[i]);
        end
        if (exp_code.size() > 0 && nb > 0)
            chk({tag, " done_after_last"}, done_cyc, last_hs_cyc + 1);
        nm = mq.size() - m0;
        chk({tag, " meta_reads"}, nm, exp_meta.size());
        for (int i = 0; i < nm && i < exp_meta.size(); i++)
            chk($sformatf("%s meta_addr%0d", tag, i), mq[m0+i], exp_meta[i]);
        np = pq.size() - p0;
        chk({tag, " ptr_reads"}, np, exp_ptr.size());
        for (int i = 0; i < np && i < exp_ptr.size(); i++)
            chk($sformatf("%s ptr_addr%0d", tag, i), pq[p0+i], exp_ptr[i]);
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 256; i++) begin
            kmin_mem[i] = 8'h00;
            off_mem[i] = 8'h00;
        end
        for (int i = 0; i < 1024; i++) ptr_mem[i] = 4'h0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " op_valid"}, int'(o_op_valid), 0);
        chk({tag, " busy"}, int'(o_busy), 0);
        chk({tag, " done"}, int'(o_done), 0);
        chk({tag, " err"}, int'(o_err), 0);
        chk({tag, " meta_rd"}, int'(o_meta_rd), 0);
        chk({tag, " ptr_rd"}, int'(o_ptr_rd), 0);
    endtask

    initial begin
        int n, d0, sc, dg, st, md;
        rdy_mode = 0;
        rst = 1'b1;
        i_start = 1'b0;
        i_start_score = '0;
        i_start_diag = '0;
        i_start_state = '0;
        clear_mems();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        chk("reset ptr_addr", int'(o_ptr_addr), 0);
        chk("reset meta_addr", int'(o_meta_addr), 0);
        chk("reset op_len", int'(o_op_len), 0);
        chk("reset op_last", int'(o_op_last), 0);
        rst = 1'b0;

        for (int s = 1; s <= 5; s++) off_mem[s] = 8'(s * 10);
        run_trace("m3", 3, 0, 0, 0);
        run_trace("m5_sat", 5, 0, 0, 0);
        run_trace("m5_hold", 5, 0, 0, 2);

        clear_mems();
        for (int s = 0; s < 256; s++) kmin_mem[s] = 8'hFC;
        off_mem[4] = 8'h40; off_mem[2] = 8'h20; off_mem[1] = 8'h10;
        ptr_mem[10'h044] = 4'b0101;
        ptr_mem[10'h023] = 4'b0001;
        ptr_mem[10'h012] = 4'b0000;
        run_trace("ins_ext", 4, 0, 0, 0);

        for (int s = 0; s < 256; s++) kmin_mem[s] = 8'hFD;
        run_trace("oow_err", 3, -5, 0, 0);
        run_trace("score0", 0, 0, 0, 0);
        run_trace("state11", 5, 0, 3, 0);

        // Abort with reset while waiting on the pointer memory.
        clear_mems();
        for (int s = 1; s <= 5; s++) off_mem[s] = 8'(s * 10);
        d0 = done_cnt;
        @(posedge clk); #1;
        i_start = 1'b1; i_start_score = 8'd5; i_start_diag = 8'd0; i_start_state = 2'b00;
        @(posedge clk); #1;
        i_start = 1'b0;
        n = 0;
        while (!o_ptr_rd && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort ptr_rd_seen", int'(o_ptr_rd), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("abort");
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("abort no_done", done_cnt - d0, 0);
        run_trace("after_abort", 3, 0, 0, 0);

        // Randomized traces with random backpressure and ignored mid-trace starts.
        rdy_mode = 1;
        for (int t = 0; t < 40; t++) begin
            for (int s = 0; s < 256; s++) begin
                kmin_mem[s] = (t % 4 == 3) ? 8'(-int'($urandom_range(0, 3)))
                                           : 8'(-int'($urandom_range(4, 30)));
                off_mem[s] = 8'($urandom_range(0, 255));
            end
            for (int i = 0; i < 1024; i++) begin
                logic [3:0] v;
                v = 4'($urandom_range(0, 15));
                if (v[1:0] == 2'b11 && $urandom_range(0, 3) != 0) v[1:0] = 2'b00;
                ptr_mem[i] = v;
            end
            sc = $urandom_range(0, 16);
            dg = int'($urandom_range(0, 8)) - 4;
            st = $urandom_range(0, 3);
            md = (sc > 0 && st != 3 && (t % 3 == 0)) ? 1 : 0;
            run_trace($sformatf("rand%0d", t), sc, dg, st, md);
        end
        rdy_mode = 0;
        chk("done_while_busy", done_busy_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
